// File: rtl/cmac_rx_gate_pkg.sv
// rtl/cmac_rx_gate_pkg.sv - shared types, terminator constants and counter helper for cmac_rx_gate
package cmac_rx_gate_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_TERM   = 2'd2
    } gate_state_t;

    // Injected terminator beat: one valid byte of zeros, flagged bad, closing the frame
    localparam int unsigned TERM_KEEP = 1;
    localparam logic        TERM_USER = 1'b1;
    localparam logic        TERM_LAST = 1'b1;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Saturating counter step; clear wins over increment
    function automatic logic [31:0] sat_next(input logic [31:0] q, input logic inc, input logic clr);
        logic [31:0] r;
        r = q;
        if (clr) begin
            r = '0;
        end else if (inc && (q != CNT_MAX)) begin
            r = q + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmac_link_debounce.sv
// rtl/cmac_link_debounce.sv - debounces PCS alignment into link_up with a link_fall pulse
module cmac_link_debounce #(
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic rx_clk,
    input  logic rx_resetn,
    input  logic sync_rx_aligned,
    output logic link_up,
    output logic link_fall
);

    localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

    logic [15:0] stable_cnt;

    // Count consecutive aligned cycles; the count parks at STABLE so it never wraps
    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            stable_cnt <= '0;
            link_up    <= 1'b0;
        end else if (!sync_rx_aligned) begin
            stable_cnt <= '0;
            link_up    <= 1'b0;
        end else begin
            if (stable_cnt != STABLE) begin
                stable_cnt <= stable_cnt + 16'd1;
            end
            if (stable_cnt >= (STABLE - 16'd1)) begin
                link_up <= 1'b1;
            end
        end
    end

    // High in the cycle whose clock edge takes link_up from 1 to 0
    always_comb begin
        link_fall = link_up & ~sync_rx_aligned;
    end

endmodule

// File: rtl/cmac_rx_gate.sv
// rtl/cmac_rx_gate.sv - forwards whole CMAC RX packets only while the link is stably aligned
module cmac_rx_gate
    import cmac_rx_gate_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned DATA_W        = 512,
    parameter int unsigned KEEP_W        = DATA_W / 8
) (
    input  logic              rx_clk,
    input  logic              rx_resetn,
    input  logic              sync_rx_aligned,
    input  logic [DATA_W-1:0] axis_in_tdata,
    input  logic [KEEP_W-1:0] axis_in_tkeep,
    input  logic              axis_in_tlast,
    input  logic              axis_in_tuser,
    input  logic              axis_in_tvalid,
    output logic [DATA_W-1:0] axis_out_tdata,
    output logic [KEEP_W-1:0] axis_out_tkeep,
    output logic              axis_out_tlast,
    output logic              axis_out_tuser,
    output logic              axis_out_tvalid,
    input  logic              clear_counts,
    output logic              link_up,
    output logic [31:0]       pkt_pass_count,
    output logic [31:0]       pkt_drop_count,
    output logic [31:0]       pkt_trunc_count,
    output logic [31:0]       link_down_count
);

    gate_state_t       state, state_nxt;
    logic              link_fall;
    logic              link_ok;
    logic              at_boundary;
    logic              in_pkt;
    logic              out_pkt;
    logic              fwd;
    logic              term;

    logic [DATA_W-1:0] tdata_nxt;
    logic [KEEP_W-1:0] tkeep_nxt;
    logic              tlast_nxt;
    logic              tuser_nxt;
    logic              tvalid_nxt;
    logic              pass_inc, drop_inc, trunc_inc, ld_inc;

    logic [31:0]       pass_cnt, drop_cnt, trunc_cnt, ld_cnt;

    cmac_link_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .rx_clk         (rx_clk),
        .rx_resetn      (rx_resetn),
        .sync_rx_aligned(sync_rx_aligned),
        .link_up        (link_up),
        .link_fall      (link_fall)
    );

    // link_up is registered, so also require alignment now: a falling cycle is never "up"
    always_comb begin
        link_ok     = link_up & sync_rx_aligned;
        at_boundary = (~in_pkt & ~axis_in_tvalid) | (axis_in_tvalid & axis_in_tlast);
    end

    // FSM state register
    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            state <= ST_CLOSED;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: open only on a boundary, close (terminating if mid-packet) when the link drops
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLOSED: if (link_ok && at_boundary) state_nxt = ST_OPEN;
            ST_OPEN:   if (!link_ok) state_nxt = out_pkt ? ST_TERM : ST_CLOSED;
            ST_TERM:   state_nxt = ST_CLOSED;
            default:   state_nxt = ST_CLOSED;
        endcase
    end

    // FSM outputs: next output beat and counter events
    always_comb begin
        fwd        = (state == ST_OPEN) & link_ok & axis_in_tvalid;
        term       = (state == ST_TERM);
        tdata_nxt  = '0;
        tkeep_nxt  = '0;
        tlast_nxt  = 1'b0;
        tuser_nxt  = 1'b0;
        tvalid_nxt = 1'b0;
        if (fwd) begin
            tdata_nxt  = axis_in_tdata;
            tkeep_nxt  = axis_in_tkeep;
            tlast_nxt  = axis_in_tlast;
            tuser_nxt  = axis_in_tuser;
            tvalid_nxt = 1'b1;
        end else if (term) begin
            tdata_nxt  = '0;
            tkeep_nxt  = KEEP_W'(TERM_KEEP);
            tlast_nxt  = TERM_LAST;
            tuser_nxt  = TERM_USER;
            tvalid_nxt = 1'b1;
        end
        pass_inc  = fwd & axis_in_tlast;
        drop_inc  = axis_in_tvalid & axis_in_tlast & (state != ST_OPEN);
        trunc_inc = term;
        ld_inc    = link_fall;
    end

    // Registered output beat plus input/output framing trackers
    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            axis_out_tdata  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tuser  <= 1'b0;
            axis_out_tvalid <= 1'b0;
            in_pkt          <= 1'b0;
            out_pkt         <= 1'b0;
        end else begin
            axis_out_tdata  <= tdata_nxt;
            axis_out_tkeep  <= tkeep_nxt;
            axis_out_tlast  <= tlast_nxt;
            axis_out_tuser  <= tuser_nxt;
            axis_out_tvalid <= tvalid_nxt;
            if (axis_in_tvalid) begin
                in_pkt <= ~axis_in_tlast;
            end
            if (term) begin
                out_pkt <= 1'b0;
            end else if (fwd) begin
                out_pkt <= ~axis_in_tlast;
            end
        end
    end

    // Saturating statistics counters, loaded every cycle from their next value
    always_ff @(posedge rx_clk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            pass_cnt  <= '0;
            drop_cnt  <= '0;
            trunc_cnt <= '0;
            ld_cnt    <= '0;
        end else begin
            pass_cnt  <= sat_next(pass_cnt, pass_inc, clear_counts);
            drop_cnt  <= sat_next(drop_cnt, drop_inc, clear_counts);
            trunc_cnt <= sat_next(trunc_cnt, trunc_inc, clear_counts);
            ld_cnt    <= sat_next(ld_cnt, ld_inc, clear_counts);
        end
    end

    assign pkt_pass_count  = pass_cnt;
    assign pkt_drop_count  = drop_cnt;
    assign pkt_trunc_count = trunc_cnt;
    assign link_down_count = ld_cnt;

endmodule

// File: tb/tb_cmac_rx_gate.sv
// tb/tb_cmac_rx_gate.sv - directed self-checking bench for cmac_rx_gate
module tb_cmac_rx_gate;

    localparam int DW = 64;
    localparam int KW = 8;

    logic          rx_clk = 1'b0;
    logic          rx_resetn = 1'b0;
    logic          sync_rx_aligned = 1'b0;
    logic [DW-1:0] in_tdata = '0;
    logic [KW-1:0] in_tkeep = '0;
    logic          in_tlast = 1'b0;
    logic          in_tuser = 1'b0;
    logic          in_tvalid = 1'b0;
    logic [DW-1:0] out_tdata;
    logic [KW-1:0] out_tkeep;
    logic          out_tlast;
    logic          out_tuser;
    logic          out_tvalid;
    logic          clear_counts = 1'b0;
    logic          link_up;
    logic [31:0]   pass_c, drop_c, trunc_c, ld_c;

    int tests = 0;
    int fails = 0;

    always #5 rx_clk = ~rx_clk;

    cmac_rx_gate #(
        .STABLE_CYCLES(1024),
        .DATA_W       (DW),
        .KEEP_W       (KW)
    ) dut (
        .rx_clk         (rx_clk),
        .rx_resetn      (rx_resetn),
        .sync_rx_aligned(sync_rx_aligned),
        .axis_in_tdata  (in_tdata),
        .axis_in_tkeep  (in_tkeep),
        .axis_in_tlast  (in_tlast),
        .axis_in_tuser  (in_tuser),
        .axis_in_tvalid (in_tvalid),
        .axis_out_tdata (out_tdata),
        .axis_out_tkeep (out_tkeep),
        .axis_out_tlast (out_tlast),
        .axis_out_tuser (out_tuser),
        .axis_out_tvalid(out_tvalid),
        .clear_counts   (clear_counts),
        .link_up        (link_up),
        .pkt_pass_count (pass_c),
        .pkt_drop_count (drop_c),
        .pkt_trunc_count(trunc_c),
        .link_down_count(ld_c)
    );

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic u, input logic [DW-1:0] d, input logic [KW-1:0] k);
        in_tvalid = v;
        in_tlast  = l;
        in_tuser  = u;
        in_tdata  = d;
        in_tkeep  = k;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // {tvalid,tlast,tuser,tkeep} in one word, tdata in another
    task automatic chk_beat(input string tag, input logic [10:0] ctl, input logic [DW-1:0] d);
        chk({tag, ".ctl"}, 64'({out_tvalid, out_tlast, out_tuser, out_tkeep}), 64'(ctl));
        chk({tag, ".data"}, out_tdata, d);
    endtask

    task automatic chk_counts(input string tag, input int p, input int dr, input int t, input int ld);
        chk({tag, ".pass"}, 64'(pass_c), 64'(p));
        chk({tag, ".drop"}, 64'(drop_c), 64'(dr));
        chk({tag, ".trunc"}, 64'(trunc_c), 64'(t));
        chk({tag, ".linkdown"}, 64'(ld_c), 64'(ld));
    endtask

    task automatic do_reset();
        rx_resetn = 1'b0;
        sync_rx_aligned = 1'b0;
        idle();
        ticks(3);
        rx_resetn = 1'b1;
        tick();
    endtask

    int n_sent;
    int saw_valid;
    int saw_link;

    initial begin
        // Reset state
        do_reset();
        chk("rst.link_up", 64'(link_up), 64'd0);
        chk("rst.tvalid", 64'(out_tvalid), 64'd0);
        chk_counts("rst", 0, 0, 0, 0);

        // Link comes up exactly STABLE_CYCLES cycles after alignment rises
        sync_rx_aligned = 1'b1;
        ticks(1023);
        chk("deb.before", 64'(link_up), 64'd0);
        tick();
        chk("deb.at", 64'(link_up), 64'd1);
        tick();  // boundary cycle lets the gate open

        // 3-beat packet forwarded unchanged, one cycle later
        drive(1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444, 8'hFF); tick();
        chk_beat("p1.b0", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'h1111_2222_3333_4444);
        drive(1'b1, 1'b0, 1'b0, 64'h5555_6666_7777_8888, 8'hFF); tick();
        chk_beat("p1.b1", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'h5555_6666_7777_8888);
        drive(1'b1, 1'b1, 1'b0, 64'h0000_0000_9999_AAAA, 8'h0F); tick();
        chk_beat("p1.b2", {1'b1, 1'b1, 1'b0, 8'h0F}, 64'h0000_0000_9999_AAAA);
        idle(); tick();
        chk("p1.idle", 64'(out_tvalid), 64'd0);
        chk_counts("p1", 1, 0, 0, 0);

        // Link rises while a 4-beat packet is on its second beat: whole packet dropped
        do_reset();
        sync_rx_aligned = 1'b1;
        ticks(1023);
        drive(1'b1, 1'b0, 1'b0, 64'hB0, 8'hFF); tick();
        chk("p2.link_up", 64'(link_up), 64'd1);
        chk("p2.b0", 64'(out_tvalid), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'hB1, 8'hFF); tick();
        chk("p2.b1", 64'(out_tvalid), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'hB2, 8'hFF); tick();
        chk("p2.b2", 64'(out_tvalid), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 64'hB3, 8'hFF); tick();
        chk("p2.b3", 64'(out_tvalid), 64'd0);
        chk_counts("p2", 0, 1, 0, 0);
        // next packet passes, bad-frame flag untouched and still counted as passed
        drive(1'b1, 1'b0, 1'b0, 64'hAAAA_0001, 8'hFF); tick();
        chk_beat("p3.b0", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'hAAAA_0001);
        drive(1'b1, 1'b1, 1'b1, 64'hAAAA_0002, 8'h03); tick();
        chk_beat("p3.b1", {1'b1, 1'b1, 1'b1, 8'h03}, 64'hAAAA_0002);
        chk_counts("p3", 1, 1, 0, 0);

        // Alignment lost on beat 2 of a 5-beat packet: 2 beats then terminator
        drive(1'b1, 1'b0, 1'b0, 64'hC0, 8'hFF); tick();
        chk_beat("p4.b0", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'hC0);
        drive(1'b1, 1'b0, 1'b0, 64'hC1, 8'hFF); tick();
        chk_beat("p4.b1", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'hC1);
        sync_rx_aligned = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 64'hC2, 8'hFF); tick();
        chk("p4.b2", 64'(out_tvalid), 64'd0);
        chk("p4.link_up", 64'(link_up), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 64'hC3, 8'hFF); tick();
        chk_beat("p4.term", {1'b1, 1'b1, 1'b1, 8'h01}, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 64'hC4, 8'hFF); tick();
        chk("p4.b4", 64'(out_tvalid), 64'd0);
        idle(); tick();
        chk_counts("p4", 1, 2, 1, 1);

        // Alignment lost on the tlast beat: that beat is replaced by a terminator
        sync_rx_aligned = 1'b1;
        ticks(1024);
        chk("p5.link_up", 64'(link_up), 64'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'hD0, 8'hFF); tick();
        chk_beat("p5.b0", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'hD0);
        drive(1'b1, 1'b0, 1'b0, 64'hD1, 8'hFF); tick();
        chk_beat("p5.b1", {1'b1, 1'b0, 1'b0, 8'hFF}, 64'hD1);
        sync_rx_aligned = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'hD2, 8'hFF); tick();
        chk("p5.b2", 64'(out_tvalid), 64'd0);
        idle(); tick();
        chk_beat("p5.term", {1'b1, 1'b1, 1'b1, 8'h01}, 64'h0);
        tick();
        chk("p5.after", 64'(out_tvalid), 64'd0);
        chk_counts("p5", 1, 2, 2, 2);

        // Alignment glitching low every 500 cycles never brings the link up
        do_reset();
        n_sent = 0;
        saw_valid = 0;
        saw_link = 0;
        for (int i = 0; i < 1500; i++) begin
            sync_rx_aligned = ((i % 500) != 499);
            if ((i % 100) == 50) begin
                drive(1'b1, 1'b1, 1'b0, 64'(i), 8'hFF);
                n_sent++;
            end else begin
                idle();
            end
            tick();
            if (out_tvalid) saw_valid++;
            if (link_up) saw_link++;
        end
        idle();
        tick();
        chk("glitch.link_up_cycles", 64'(saw_link), 64'd0);
        chk("glitch.out_beats", 64'(saw_valid), 64'd0);
        chk_counts("glitch", 0, 15, 0, 0);
        chk("glitch.sent", 64'(drop_c), 64'(n_sent));

        // Saturation at 0xFFFFFFFF and clear priority
        sync_rx_aligned = 1'b1;
        ticks(1025);
        chk("sat.link_up", 64'(link_up), 64'd1);
        force dut.pass_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.pass_cnt;
        chk("sat.preload", 64'(pass_c), 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 64'hE0 + 64'(i), 8'hFF);
            tick();
            chk_beat("sat.pkt", {1'b1, 1'b1, 1'b0, 8'hFF}, 64'hE0 + 64'(i));
            chk("sat.count", 64'(pass_c), 64'hFFFF_FFFF);
        end
        clear_counts = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'hF0, 8'hFF);
        tick();
        clear_counts = 1'b0;
        chk_beat("clr.pkt", {1'b1, 1'b1, 1'b0, 8'hFF}, 64'hF0);
        chk_counts("clr", 0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 64'hF1, 8'hFF);
        tick();
        idle();
        chk("clr.recount", 64'(pass_c), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmac_rx_gate.md
# cmac_rx_gate

Packet-integrity gate on the CMAC RX AXI-Stream path, placed directly downstream of `cmac_control` and the CMAC's `rx_axis` output. It debounces `sync_rx_aligned` into a `link_up` flag and forwards only whole packets while the link is up. A packet cut off by loss of alignment is closed with an injected error-flagged terminator beat. It keeps saturating counters of passed, dropped and truncated packets and of link-down events.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1024: consecutive `sync_rx_aligned`-high cycles required before `link_up` asserts; legal range 1..65535.
- `DATA_W`, default 512: AXIS data width; `KEEP_W` = `DATA_W`/8.

Ports:
- `rx_clk`  in  1  CMAC RX user clock (322.265625 MHz); the only clock.
- `rx_resetn`  in  1  asynchronous, active-low reset.
- `sync_rx_aligned`  in  1  PCS alignment, already synchronous to `rx_clk`.
- `axis_in_tdata/tkeep/tlast/tuser/tvalid`  in  DATA_W/KEEP_W/1/1/1  CMAC RX stream; no `tready`; `tuser` marks a bad frame.
- `axis_out_tdata/tkeep/tlast/tuser/tvalid`  out  same widths  gated stream; no backpressure.
- `clear_counts`  in  1  synchronous pulse; zeroes all counters.
- `link_up`  out  1  debounced alignment.
- `pkt_pass_count`, `pkt_drop_count`, `pkt_trunc_count`, `link_down_count`  out  32 each  saturating counters.

## Operation
- Debounce: a 16-bit counter increments while `sync_rx_aligned`=1 and clears to 0 when it is 0. `link_up` sets when the count reaches `STABLE_CYCLES`. It clears on the first cycle `sync_rx_aligned`=0.
- `in_pkt` tracks the input framing. It sets on `tvalid & ~tlast` and clears on `tvalid & tlast`.
- FSM has three states: CLOSED, OPEN, TERM.
  - CLOSED -> OPEN when `link_up`=1 and the input is at a packet boundary. A boundary is `in_pkt`=0 with no valid beat this cycle, or a valid beat with `tlast`=1, which is itself dropped. This guarantees the first forwarded beat starts a packet.
  - OPEN: every valid beat is forwarded.
  - OPEN -> TERM on `link_up` falling while `out_pkt`=1, i.e. a forwarded packet is incomplete. The beat in that cycle is not forwarded.
  - OPEN -> CLOSED on `link_up` falling with `out_pkt`=0.
  - TERM: emit one beat with `tvalid`=1, `tlast`=1, `tuser`=1, `tkeep`=1, `tdata`=0, then go to CLOSED.
- Counters:
  - pass: each forwarded `tlast` beat.
  - drop: each `tlast` beat that arrives while CLOSED or TERM.
  - trunc: each terminator emitted.
  - link_down: each 1->0 transition of `link_up`.
- All counters saturate at 0xFFFFFFFF. `clear_counts` takes priority over any increment in the same cycle.
- Forwarded `tuser` passes through unchanged. A passed packet with `tuser`=1 still counts as passed.

## Timing
- Output is fully registered: an input beat at cycle n appears at cycle n+1.
- `link_up` rises at cycle k+`STABLE_CYCLES` when `sync_rx_aligned` rises at cycle k and stays high. It falls one cycle after `sync_rx_aligned` falls.
- The terminator appears on the output one cycle after the cycle in which `link_up` is seen low.
- `axis_out_tvalid` is never high for two packets without an intervening `tlast`.
- Async reset (`rx_resetn`=0) has the following effects:
  - All outputs go to 0, including `link_up` and the counters.
  - The FSM goes to CLOSED, and `in_pkt`/`out_pkt` go to 0.
  - A packet in flight at reset is not terminated.
  - The first input beats after reset may be a packet tail. `in_pkt`=0 treats the next `tlast` as a boundary, so a tail arriving while CLOSED counts as dropped.

## Structure
- Package `cmac_rx_gate_pkg` holds the FSM state enum and the terminator beat constants (`TERM_KEEP`, `TERM_USER`).
- Sub-module `cmac_link_debounce` contains the debounce counter and generates `link_up` plus a one-cycle `link_fall` pulse.

## Test plan
- Align high for 1024 cycles, then send a 3-beat packet -> `link_up` rises at cycle 1024; the packet exits 1 cycle later, unchanged; pass=1.
- Enable alignment while a 4-beat packet is on beat 2 -> the partial packet is not forwarded; drop=1; the next full packet passes.
- Drop alignment on beat 2 of a 5-beat forwarded packet -> the output is 2 beats followed by a terminator (`tlast`=1, `tuser`=1, `tkeep`=1); trunc=1; link_down=1.
- Drop alignment in the same cycle as a `tlast` beat -> that beat is not forwarded; the terminator is emitted; trunc=1.
- Toggle alignment low for 1 cycle every 500 cycles -> `link_up` never asserts; no output beats; link_down=0.
- Preload a counter to 0xFFFFFFFE and pass 3 packets -> it holds at 0xFFFFFFFF; `clear_counts` pulse -> 0 on the next cycle.
